// File: rtl/clk_activity_monitor_if.sv
// Bundle of control, bound and result signals for clk_activity_monitor.
// The master side drives enable, clear_err, ch_in and bounds; the slave side returns results.
interface clk_activity_monitor_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
);
    logic                      enable;
    logic                      clear_err;
    logic [NUM_CH-1:0]         ch_in;
    logic [NUM_CH*CNT_W-1:0]   exp_min;
    logic [NUM_CH*CNT_W-1:0]   exp_max;
    logic [NUM_CH*CNT_W-1:0]   meas_count;
    logic                      meas_valid;
    logic [NUM_CH-1:0]         err_low;
    logic [NUM_CH-1:0]         err_high;
    logic                      err_any;
    logic                      busy;

    modport master (
        output enable, clear_err, ch_in, exp_min, exp_max,
        input  meas_count, meas_valid, err_low, err_high, err_any, busy
    );

    modport slave (
        input  enable, clear_err, ch_in, exp_min, exp_max,
        output meas_count, meas_valid, err_low, err_high, err_any, busy
    );
endinterface

// File: rtl/clk_activity_monitor.sv
// Counts rising edges on NUM_CH asynchronous channels over back-to-back windows and flags out-of-range counts.
// Optional macro CLK_MON_GLITCH_FILTER_EN adds a sync stage and ignores single-cycle pulses.
module clk_activity_monitor #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1000
) (
    input  logic                  ext_clk,
    input  logic                  reset,
    clk_activity_monitor_if.slave bus
);
    localparam int WIN_W = $clog2(WINDOW);

    typedef enum logic [1:0] {IDLE, MEASURE, EVAL} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [WIN_W-1:0]        win_cnt;
    logic                    win_last;
    logic                    win_done;

    logic [NUM_CH-1:0]       sync1;
    logic [NUM_CH-1:0]       sync2;
    logic [NUM_CH-1:0]       sync3;
    logic [NUM_CH-1:0]       edge_det;

    logic [CNT_W-1:0]        cnt     [NUM_CH];
    logic [CNT_W-1:0]        cnt_inc [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] meas_next;
    logic [NUM_CH*CNT_W-1:0] meas_q;
    logic [NUM_CH-1:0]       low_hit;
    logic [NUM_CH-1:0]       high_hit;
    logic [NUM_CH-1:0]       err_low_q;
    logic [NUM_CH-1:0]       err_high_q;

`ifdef CLK_MON_GLITCH_FILTER_EN
    logic [NUM_CH-1:0]       sync4;

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            sync4 <= '0;
        end else begin
            sync1 <= bus.ch_in;
            sync2 <= sync1;
            sync3 <= sync2;
            sync4 <= sync3;
        end
    end

    // A level must be seen high for two cycles after being low before it counts.
    assign edge_det = sync2 & sync3 & ~sync4;
`else
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= bus.ch_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_det = sync2 & ~sync3;
`endif

    assign win_last = (win_cnt == WIN_W'(WINDOW - 1));
    assign win_done = (state == MEASURE) && bus.enable && win_last;

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.enable) state_next = MEASURE;
            MEASURE: begin
                if (!bus.enable) begin
                    state_next = IDLE;
                end else if (win_last) begin
                    state_next = EVAL;
                end
            end
            EVAL:    state_next = bus.enable ? MEASURE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state == MEASURE) || (state == EVAL);
        bus.meas_valid = (state == EVAL);
    end

    // Saturating next count; the last MEASURE cycle's edge is folded in before it is published.
    always_comb begin
        meas_next = '0;
        low_hit   = '0;
        high_hit  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_inc[i] = cnt[i];
            if (edge_det[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                cnt_inc[i] = cnt[i] + CNT_W'(1);
            end
            meas_next[i*CNT_W +: CNT_W] = cnt_inc[i];
            low_hit[i]  = cnt_inc[i] < bus.exp_min[i*CNT_W +: CNT_W];
            high_hit[i] = cnt_inc[i] > bus.exp_max[i*CNT_W +: CNT_W];
        end
    end

    // Counters only run in MEASURE, so every entry into MEASURE starts from zero.
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            win_cnt    <= '0;
            meas_q     <= '0;
            err_low_q  <= '0;
            err_high_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (state == MEASURE) begin
                win_cnt <= win_cnt + WIN_W'(1);
            end else begin
                win_cnt <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= (state == MEASURE) ? cnt_inc[i] : '0;
            end
            if (win_done) begin
                meas_q <= meas_next;
            end
            err_low_q  <= (bus.clear_err ? '0 : err_low_q)  | (win_done ? low_hit  : '0);
            err_high_q <= (bus.clear_err ? '0 : err_high_q) | (win_done ? high_hit : '0);
        end
    end

    assign bus.meas_count = meas_q;
    assign bus.err_low    = err_low_q;
    assign bus.err_high   = err_high_q;
    assign bus.err_any    = (|err_low_q) | (|err_high_q);

endmodule

// File: tb/tb_clk_activity_monitor.sv
// Scoreboard bench for clk_activity_monitor: a 16-bit main instance and a 4-bit saturation instance.
// Expected window results are queued when a window is started and popped when meas_valid appears.
module tb_clk_activity_monitor;
    localparam int WINDOW = 100;

`ifdef CLK_MON_GLITCH_FILTER_EN
    localparam logic [15:0] GLITCH_EXP = 16'd0;
`else
    localparam logic [15:0] GLITCH_EXP = 16'd10;
`endif

    typedef struct packed {
        logic [31:0] count;
        logic [1:0]  low;
        logic [1:0]  high;
    } exp_t;

    logic ext_clk;
    logic reset;
    int   gcyc;
    int   mode;
    int   n_compared;
    int   n_mismatched;
    exp_t sb_q[$];

    clk_activity_monitor_if #(.NUM_CH(2), .CNT_W(16)) mon_if ();
    clk_activity_monitor_if #(.NUM_CH(2), .CNT_W(4))  sat_if ();

    clk_activity_monitor #(.NUM_CH(2), .CNT_W(16), .WINDOW(WINDOW)) dut (
        .ext_clk (ext_clk),
        .reset   (reset),
        .bus     (mon_if.slave)
    );

    clk_activity_monitor #(.NUM_CH(2), .CNT_W(4), .WINDOW(WINDOW)) dut_sat (
        .ext_clk (ext_clk),
        .reset   (reset),
        .bus     (sat_if.slave)
    );

    initial begin
        ext_clk = 1'b0;
        forever #5 ext_clk = ~ext_clk;
    end

    // Channel patterns: 1 = period 4 on ch0, 2 = one-cycle pulse every 10 cycles; sat ch0 toggles always.
    task automatic tick();
        logic p4;
        logic p10;
        @(posedge ext_clk);
        #1;
        gcyc++;
        p4  = (gcyc % 4) < 2;
        p10 = (gcyc % 10) == 0;
        case (mode)
            1:       mon_if.ch_in = {1'b0, p4};
            2:       mon_if.ch_in = {1'b0, p10};
            default: mon_if.ch_in = 2'b00;
        endcase
        sat_if.ch_in = {1'b0, gcyc[0]};
        @(negedge ext_clk);
    endtask

    task automatic run_until_valid(input bit use_sat, input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if ((use_sat ? sat_if.meas_valid : mon_if.meas_valid) === 1'b1) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_compared++;
        if (mon_if.meas_count !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %h expected %h", mon_if.meas_count, 32'h0); end
        n_compared++;
        if (mon_if.meas_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", mon_if.meas_valid); end
        n_compared++;
        if (mon_if.err_low !== 2'b00 || mon_if.err_high !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_err: got low=%b high=%b expected 00/00", mon_if.err_low, mon_if.err_high); end
        n_compared++;
        if (mon_if.err_any !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_err_any: got %b expected 0", mon_if.err_any); end
        n_compared++;
        if (mon_if.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", mon_if.busy); end
        n_compared++;
        if (sat_if.meas_count !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_sat_count: got %h expected 00", sat_if.meas_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int   w;
        exp_t e;
        mon_if.exp_min = {16'd1, 16'd24};
        mon_if.exp_max = {16'd5, 16'd26};
        mode = 1;
        repeat (6) tick();
        e = '{count: {16'd0, 16'd25}, low: 2'b10, high: 2'b00};
        sb_q.push_back(e);
        mon_if.enable = 1'b1;
        tick();
        n_compared++;
        if (mon_if.busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_busy: got %b expected 1", mon_if.busy); end
        run_until_valid(1'b0, WINDOW + 10, w);
        mon_if.enable = 1'b0;
        n_compared++;
        if (w != WINDOW) begin n_mismatched++; $display("[TB] FAIL basic_latency: got %0d expected %0d", w, WINDOW); end
        e = sb_q.pop_front();
        n_compared++;
        if (mon_if.meas_count !== e.count) begin n_mismatched++; $display("[TB] FAIL basic_count: got %h expected %h", mon_if.meas_count, e.count); end
        n_compared++;
        if (mon_if.err_low !== e.low || mon_if.err_high !== e.high) begin n_mismatched++; $display("[TB] FAIL basic_err: got low=%b high=%b expected %b/%b", mon_if.err_low, mon_if.err_high, e.low, e.high); end
        n_compared++;
        if (mon_if.err_any !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_err_any: got %b expected 1", mon_if.err_any); end
        tick();
        n_compared++;
        if (mon_if.busy !== 1'b0 || mon_if.meas_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_idle: got busy=%b valid=%b expected 0/0", mon_if.busy, mon_if.meas_valid); end
        repeat (3) tick();
        n_compared++;
        if (mon_if.meas_count !== e.count) begin n_mismatched++; $display("[TB] FAIL basic_hold: got %h expected %h", mon_if.meas_count, e.count); end
    endtask

    task automatic test_err_high();
        int   w;
        exp_t e;
        mon_if.clear_err = 1'b1;
        tick();
        mon_if.clear_err = 1'b0;
        n_compared++;
        if (mon_if.err_any !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clear_idle: got %b expected 0", mon_if.err_any); end
        mon_if.exp_min = {16'd0, 16'd10};
        mon_if.exp_max = {16'd5, 16'd20};
        e = '{count: {16'd0, 16'd25}, low: 2'b00, high: 2'b01};
        sb_q.push_back(e);
        mon_if.enable = 1'b1;
        run_until_valid(1'b0, WINDOW + 10, w);
        mon_if.enable = 1'b0;
        e = sb_q.pop_front();
        n_compared++;
        if (w < 0) begin
            n_mismatched++; $display("[TB] FAIL err_high_timeout: got no meas_valid expected one within %0d", WINDOW + 10);
        end else if (mon_if.meas_count !== e.count || mon_if.err_low !== e.low || mon_if.err_high !== e.high) begin
            n_mismatched++; $display("[TB] FAIL err_high: got %h low=%b high=%b expected %h %b/%b", mon_if.meas_count, mon_if.err_low, mon_if.err_high, e.count, e.low, e.high);
        end
        tick();
    endtask

    task automatic test_inverted_bounds();
        int   w;
        exp_t e;
        mon_if.clear_err = 1'b1;
        tick();
        mon_if.clear_err = 1'b0;
        mon_if.exp_min = {16'd0, 16'd30};
        mon_if.exp_max = {16'd0, 16'd20};
        e = '{count: {16'd0, 16'd25}, low: 2'b01, high: 2'b01};
        sb_q.push_back(e);
        mon_if.enable = 1'b1;
        run_until_valid(1'b0, WINDOW + 10, w);
        mon_if.enable = 1'b0;
        e = sb_q.pop_front();
        n_compared++;
        if (w < 0) begin
            n_mismatched++; $display("[TB] FAIL inverted_timeout: got no meas_valid expected one within %0d", WINDOW + 10);
        end else if (mon_if.err_low !== e.low || mon_if.err_high !== e.high) begin
            n_mismatched++; $display("[TB] FAIL inverted_err: got low=%b high=%b expected %b/%b", mon_if.err_low, mon_if.err_high, e.low, e.high);
        end
        tick();
    endtask

    task automatic test_saturation();
        int   w;
        exp_t e;
        sat_if.exp_min = 8'h00;
        sat_if.exp_max = {4'd15, 4'd15};
        e = '{count: 32'h0000_000F, low: 2'b00, high: 2'b00};
        sb_q.push_back(e);
        sat_if.enable = 1'b1;
        run_until_valid(1'b1, WINDOW + 10, w);
        sat_if.enable = 1'b0;
        e = sb_q.pop_front();
        n_compared++;
        if (w < 0) begin n_mismatched++; $display("[TB] FAIL sat_timeout: got no meas_valid expected one within %0d", WINDOW + 10); end
        n_compared++;
        if ({24'd0, sat_if.meas_count} !== e.count) begin n_mismatched++; $display("[TB] FAIL sat_count: got %h expected %h", sat_if.meas_count, e.count); end
        n_compared++;
        if (sat_if.err_high !== e.high || sat_if.err_low !== e.low) begin n_mismatched++; $display("[TB] FAIL sat_err: got low=%b high=%b expected %b/%b", sat_if.err_low, sat_if.err_high, e.low, e.high); end
        tick();
    endtask

    task automatic test_abort();
        bit seen_valid;
        seen_valid = 1'b0;
        mon_if.enable = 1'b1;
        repeat (50) begin
            tick();
            if (mon_if.meas_valid === 1'b1) seen_valid = 1'b1;
        end
        mon_if.enable = 1'b0;
        tick();
        if (mon_if.meas_valid === 1'b1) seen_valid = 1'b1;
        n_compared++;
        if (mon_if.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", mon_if.busy); end
        repeat (4) begin
            tick();
            if (mon_if.meas_valid === 1'b1) seen_valid = 1'b1;
        end
        n_compared++;
        if (seen_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_valid: got %b expected 0", seen_valid); end
        n_compared++;
        if (mon_if.meas_count !== {16'd0, 16'd25}) begin n_mismatched++; $display("[TB] FAIL abort_count: got %h expected %h", mon_if.meas_count, {16'd0, 16'd25}); end
        n_compared++;
        if (mon_if.err_low !== 2'b01 || mon_if.err_high !== 2'b01) begin n_mismatched++; $display("[TB] FAIL abort_err: got low=%b high=%b expected 01/01", mon_if.err_low, mon_if.err_high); end
    endtask

    task automatic test_clear_coincide();
        exp_t e;
        mon_if.clear_err = 1'b1;
        tick();
        mon_if.clear_err = 1'b0;
        mon_if.exp_min = {16'd0, 16'd30};
        mon_if.exp_max = {16'd5, 16'd40};
        e = '{count: {16'd0, 16'd25}, low: 2'b01, high: 2'b00};
        sb_q.push_back(e);
        mon_if.enable = 1'b1;
        repeat (WINDOW) tick();
        // The edge that enters EVAL samples clear_err together with the new error.
        mon_if.clear_err = 1'b1;
        tick();
        n_compared++;
        if (mon_if.meas_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL coincide_valid: got %b expected 1", mon_if.meas_valid); end
        e = sb_q.pop_front();
        n_compared++;
        if (mon_if.meas_count !== e.count || mon_if.err_low !== e.low) begin n_mismatched++; $display("[TB] FAIL coincide_set: got %h low=%b expected %h %b", mon_if.meas_count, mon_if.err_low, e.count, e.low); end
        mon_if.enable = 1'b0;
        tick();
        mon_if.clear_err = 1'b0;
        n_compared++;
        if (mon_if.err_low !== 2'b00) begin n_mismatched++; $display("[TB] FAIL coincide_clear: got %b expected 00", mon_if.err_low); end
    endtask

    task automatic test_glitch();
        int   w;
        exp_t e;
        mon_if.clear_err = 1'b1;
        tick();
        mon_if.clear_err = 1'b0;
        mon_if.exp_min = 32'h0;
        mon_if.exp_max = {16'hFFFF, 16'hFFFF};
        mode = 2;
        repeat (6) tick();
        e = '{count: {16'd0, GLITCH_EXP}, low: 2'b00, high: 2'b00};
        sb_q.push_back(e);
        mon_if.enable = 1'b1;
        run_until_valid(1'b0, WINDOW + 10, w);
        mon_if.enable = 1'b0;
        e = sb_q.pop_front();
        n_compared++;
        if (w < 0) begin
            n_mismatched++; $display("[TB] FAIL glitch_timeout: got no meas_valid expected one within %0d", WINDOW + 10);
        end else if (mon_if.meas_count !== e.count) begin
            n_mismatched++; $display("[TB] FAIL glitch_count: got %h expected %h", mon_if.meas_count, e.count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   pulses;
        int   t [3];
        pulses = 0;
        t = '{0, 0, 0};
        mon_if.clear_err = 1'b1;
        tick();
        mon_if.clear_err = 1'b0;
        mon_if.exp_min = {16'd1, 16'd24};
        mon_if.exp_max = {16'd5, 16'd26};
        mode = 1;
        repeat (6) tick();
        e = '{count: {16'd0, 16'd25}, low: 2'b10, high: 2'b00};
        repeat (3) sb_q.push_back(e);
        mon_if.enable = 1'b1;
        for (int i = 1; i <= 3 * (WINDOW + 1) + 20; i++) begin
            tick();
            if (mon_if.meas_valid === 1'b1) begin
                t[pulses] = i;
                e = sb_q.pop_front();
                n_compared++;
                if (mon_if.meas_count !== e.count || mon_if.err_low !== e.low) begin
                    n_mismatched++; $display("[TB] FAIL b2b_window%0d: got %h low=%b expected %h %b", pulses, mon_if.meas_count, mon_if.err_low, e.count, e.low);
                end
                pulses++;
                if (pulses == 3) begin
                    mon_if.enable = 1'b0;
                    break;
                end
            end
        end
        mon_if.enable = 1'b0;
        n_compared++;
        if (pulses != 3) begin n_mismatched++; $display("[TB] FAIL b2b_pulses: got %0d expected 3", pulses); end
        n_compared++;
        if (t[1] - t[0] != WINDOW + 1 || t[2] - t[1] != WINDOW + 1) begin
            n_mismatched++; $display("[TB] FAIL b2b_spacing: got %0d,%0d expected %0d", t[1] - t[0], t[2] - t[1], WINDOW + 1);
        end
        tick();
        mon_if.enable = 1'b1;
        repeat (30) tick();
        n_compared++;
        if (mon_if.busy !== 1'b1 || mon_if.err_low !== 2'b10) begin n_mismatched++; $display("[TB] FAIL pre_reset: got busy=%b low=%b expected 1/10", mon_if.busy, mon_if.err_low); end
        reset = 1'b1;
        mon_if.enable = 1'b0;
        tick();
        n_compared++;
        if (mon_if.meas_count !== 32'h0 || mon_if.meas_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_count: got %h valid=%b expected 0/0", mon_if.meas_count, mon_if.meas_valid); end
        n_compared++;
        if (mon_if.err_low !== 2'b00 || mon_if.err_any !== 1'b0 || mon_if.busy !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL midreset_flags: got low=%b any=%b busy=%b expected 00/0/0", mon_if.err_low, mon_if.err_any, mon_if.busy);
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        n_compared       = 0;
        n_mismatched     = 0;
        gcyc             = 0;
        mode             = 0;
        reset            = 1'b1;
        mon_if.enable    = 1'b0;
        mon_if.clear_err = 1'b0;
        mon_if.ch_in     = 2'b00;
        mon_if.exp_min   = 32'h0;
        mon_if.exp_max   = 32'h0;
        sat_if.enable    = 1'b0;
        sat_if.clear_err = 1'b0;
        sat_if.ch_in     = 2'b00;
        sat_if.exp_min   = 8'h00;
        sat_if.exp_max   = 8'h00;

        test_reset();
        test_basic();
        test_err_high();
        test_inverted_bounds();
        test_saturation();
        test_abort();
        test_clear_coincide();
        test_glitch();
        test_back_to_back();

        n_compared++;
        if (sb_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/clk_activity_monitor.md
CLK_ACTIVITY_MONITOR -- requirements
Module: clk_activity_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of monitored channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, edge-counter and bound width.
REQ-003 SHALL have parameter WINDOW, default 1000, measurement window length in ext_clk cycles (>=4).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 ext_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 enable  in  1  level; 1 = run back-to-back windows.
REQ-008 clear_err  in  1  pulse; clears the sticky error flags.
REQ-009 ch_in  in  NUM_CH  asynchronous monitored signals, one bit per channel.
REQ-010 exp_min  in  NUM_CH*CNT_W  per-channel minimum edge count; channel i is at [i*CNT_W +: CNT_W].
REQ-011 exp_max  in  NUM_CH*CNT_W  per-channel maximum edge count, same packing as exp_min.
REQ-012 meas_count  out  NUM_CH*CNT_W  last completed window's counts, same packing as exp_min.
REQ-013 meas_valid  out  1  one-cycle pulse when meas_count updates.
REQ-014 err_low / err_high  out  NUM_CH each  sticky per-channel under-count / over-count flags.
REQ-015 err_any  out  1  OR of all err_low and err_high bits.
REQ-016 busy  out  1  high in MEASURE and EVAL states.

Function
REQ-017 Each ch_in bit SHALL pass a 2-flop synchronizer; a rising edge is sync-stage 1 & ~previous-stage, so detection latency is 3 cycles.
REQ-018 FSM states SHALL be IDLE, MEASURE and EVAL; reset enters IDLE.
REQ-019 IDLE -> MEASURE when enable=1; on entry, window counter and all edge counters clear to 0.
REQ-020 MEASURE SHALL last exactly WINDOW cycles and count detected rising edges in each of those cycles, last cycle included.
REQ-021 Edge counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 MEASURE with enable=0 -> IDLE next cycle; window discarded, no meas_valid pulse, outputs and error flags unchanged.
REQ-023 After the final MEASURE cycle the FSM SHALL enter EVAL for one cycle, in which meas_count holds the new counts and meas_valid=1.
REQ-024 In that same edge err_low[i] SHALL set if count_i < exp_min_i, and err_high[i] SHALL set if count_i > exp_max_i (unsigned compare).
REQ-025 EVAL -> MEASURE (counters cleared, zero dead cycles between windows) if enable=1, else EVAL -> IDLE.
REQ-026 Error flags SHALL stay set until clear_err or reset; when clear_err and a new error set coincide, the set SHALL win.
REQ-027 If exp_min_i > exp_max_i, both flags SHALL be evaluated independently, with no special casing.
REQ-028 meas_count SHALL hold its value between meas_valid pulses.

Reset
REQ-029 Reset SHALL force: state IDLE; synchronizers, counters and meas_count to 0; meas_valid, err_low, err_high, err_any and busy to 0.
REQ-030 Reset asserted mid-window SHALL abort the window with no meas_valid pulse, and reset SHALL take priority over every other input.

Configuration
REQ-031 Macro CLK_MON_GLITCH_FILTER_EN, when defined, SHALL add a third sync stage and count an edge only when the synchronized level has been 1 for 2 consecutive cycles after being 0 (detection latency 4 cycles).
REQ-032 Without CLK_MON_GLITCH_FILTER_EN, edges SHALL be detected per REQ-017, so a 1-cycle-wide pulse is counted.

Verification
REQ-033 NUM_CH=2, WINDOW=100, ch0 period 4 cycles, ch1 held 0, bounds ch0 24..26 and ch1 1..5 -> meas_count ch0=25, ch1=0; err_low=2'b10, err_high=0, err_any=1.
REQ-034 CNT_W=4, WINDOW=100, ch0 toggling every cycle, exp_max=15 -> ch0 meas_count=15 (saturated), err_high[0]=0.
REQ-035 enable dropped at cycle 50 of a window -> no meas_valid, busy=0 one cycle later, meas_count unchanged.
REQ-036 clear_err pulsed in the same cycle as an EVAL that sets err_low[0] -> err_low[0]=1; clear_err alone a cycle later -> err_low[0]=0.
REQ-037 Isolated 1-cycle pulses on ch0 (10 per window) -> count 10 without the macro, 0 with CLK_MON_GLITCH_FILTER_EN defined.
REQ-038 enable held high for 3 windows -> exactly 3 meas_valid pulses spaced WINDOW+1 cycles apart, and reset mid-window clears all outputs next cycle.
